// File: rtl/vc_rx_demux.sv
// Router-side receiver for the slot-multiplexed VC injection port: steers flits into per-VC FWFT FIFOs and checks framing.
// Optional per-VC packet/flit counters are enabled with the VC_RX_STATS_EN macro.
module vc_rx_demux #(
    parameter int VC         = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic [$clog2(VC)-1:0]      slot,
    output logic [VC*DATA_WIDTH-1:0]   vc_data_out,
    output logic [VC-1:0]              vc_valid_out,
    input  logic [VC-1:0]              vc_ready_out,
    output logic [VC*8-1:0]            vc_dest,
    output logic [VC-1:0]              vc_err
`ifdef VC_RX_STATS_EN
    ,
    output logic [VC*16-1:0]           vc_pkt_cnt,
    output logic [VC*16-1:0]           vc_flit_cnt
`endif
);

    localparam int SLOT_W = $clog2(VC);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } frame_state_t;

    logic [SLOT_W-1:0] slot_reg;
    logic [VC-1:0]     full;
    logic [VC-1:0]     wr_en;
    logic [1:0]        flit_type;

    assign flit_type = data_in[31:30];
    assign slot      = slot_reg;
    // Depends only on the slot and pre-pop occupancy, never on valid_in.
    assign ready_in  = !full[slot_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else if (slot_reg == SLOT_W'(VC - 1)) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_reg + SLOT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VC; gi++) begin : g_vc
            logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic                  pop;
            frame_state_t          state_reg;
            frame_state_t          state_next;
            logic                  err_reg;
            logic                  err_next;
            logic [7:0]            dest_reg;
            logic [7:0]            dest_next;

            assign wr_en[gi] = valid_in && ready_in && (slot_reg == SLOT_W'(gi));
            assign pop       = (count_reg != '0) && vc_ready_out[gi];
            assign full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));

            assign vc_valid_out[gi] = (count_reg != '0);
            // Gated so an empty FIFO presents zero rather than stale storage.
            assign vc_data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
                vc_valid_out[gi] ? mem[rd_ptr_reg] : '0;
            assign vc_dest[gi*8 +: 8] = dest_reg;
            assign vc_err[gi]         = err_reg;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[wr_ptr_reg] <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_en[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_reg + CNT_W'(wr_en[gi]) - CNT_W'(pop);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    err_reg   <= 1'b0;
                    dest_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    err_reg   <= err_next;
                    dest_reg  <= dest_next;
                end
            end

            // Framing only flags; every accepted flit is stored regardless.
            always_comb begin
                state_next = state_reg;
                err_next   = err_reg;
                dest_next  = dest_reg;
                if (wr_en[gi]) begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (flit_type == FT_HEAD) begin
                                state_next = ST_IN_PKT;
                                dest_next  = data_in[7:0];
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        ST_IN_PKT: begin
                            case (flit_type)
                                FT_BODY: state_next = ST_IN_PKT;
                                FT_TAIL: state_next = ST_IDLE;
                                FT_HEAD: begin
                                    err_next  = 1'b1;
                                    dest_next = data_in[7:0];
                                end
                                default: err_next = 1'b1;
                            endcase
                        end
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
        end
    endgenerate

`ifdef VC_RX_STATS_EN
    logic [VC*16-1:0] pkt_cnt_reg;
    logic [VC*16-1:0] flit_cnt_reg;

    assign vc_pkt_cnt  = pkt_cnt_reg;
    assign vc_flit_cnt = flit_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_reg  <= '0;
            flit_cnt_reg <= '0;
        end else begin
            for (int v = 0; v < VC; v++) begin
                if (wr_en[v]) begin
                    flit_cnt_reg[v*16 +: 16] <= flit_cnt_reg[v*16 +: 16] + 16'd1;
                    if (flit_type == FT_TAIL) begin
                        pkt_cnt_reg[v*16 +: 16] <= pkt_cnt_reg[v*16 +: 16] + 16'd1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_rx_demux.sv
// Self-checking bench for vc_rx_demux: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_vc_rx_demux;

    localparam int VC = 4;
    localparam int DW = 32;
    localparam int FD = 4;

    logic                 clk;
    logic                 rst;
    logic [DW-1:0]        data_in;
    logic                 valid_in;
    logic                 ready_in;
    logic [1:0]           slot;
    logic [VC*DW-1:0]     vc_data_out;
    logic [VC-1:0]        vc_valid_out;
    logic [VC-1:0]        vc_ready_out;
    logic [VC*8-1:0]      vc_dest;
    logic [VC-1:0]        vc_err;
`ifdef VC_RX_STATS_EN
    logic [VC*16-1:0]     vc_pkt_cnt;
    logic [VC*16-1:0]     vc_flit_cnt;
`endif

    int errors = 0;
    int checks = 0;

    vc_rx_demux #(.VC(VC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .slot         (slot),
        .vc_data_out  (vc_data_out),
        .vc_valid_out (vc_valid_out),
        .vc_ready_out (vc_ready_out),
        .vc_dest      (vc_dest),
        .vc_err       (vc_err)
`ifdef VC_RX_STATS_EN
        ,
        .vc_pkt_cnt   (vc_pkt_cnt),
        .vc_flit_cnt  (vc_flit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one queue per VC, slot as a cycle counter mod VC, framing as a flag.
    logic [DW-1:0] mq [VC][$];
    int            m_slot;
    bit            m_inpkt [VC];
    logic [VC-1:0] m_err;
    logic [7:0]    m_dest [VC];

    function automatic logic [VC-1:0] exp_valid();
        logic [VC-1:0] r;
        for (int k = 0; k < VC; k++) r[k] = (mq[k].size() != 0);
        return r;
    endfunction

    function automatic logic [VC*DW-1:0] exp_data();
        logic [VC*DW-1:0] r;
        r = '0;
        for (int k = 0; k < VC; k++) if (mq[k].size() != 0) r[k*DW +: DW] = mq[k][0];
        return r;
    endfunction

    function automatic logic [VC*8-1:0] exp_dest();
        logic [VC*8-1:0] r;
        for (int k = 0; k < VC; k++) r[k*8 +: 8] = m_dest[k];
        return r;
    endfunction

    function automatic logic [DW-1:0] pkt_flit(input int s, input int k);
        int kk;
        kk = k % 4;
        if (kk == 0) return {2'b01, 14'(s), 8'h12, 8'(s + 2)};
        if (kk == 3) return {2'b11, 14'(s), 16'd2};
        return {2'b10, 14'(s), 16'(kk - 1)};
    endfunction

    // Drive one cycle, advance the model across the rising edge, return at the falling edge.
    task automatic tick(input logic r, input logic v, input logic [DW-1:0] d, input logic [VC-1:0] rd);
        int  s;
        bit  acc;
        rst = r; valid_in = v; data_in = d; vc_ready_out = rd;
        @(posedge clk);
        s = m_slot;
        if (r) begin
            for (int k = 0; k < VC; k++) begin
                mq[k].delete();
                m_inpkt[k] = 0;
                m_dest[k]  = 8'h00;
            end
            m_err  = '0;
            m_slot = 0;
        end else begin
            acc = v && (mq[s].size() < FD);
            for (int k = 0; k < VC; k++) if (mq[k].size() != 0 && rd[k]) void'(mq[k].pop_front());
            if (acc) begin
                mq[s].push_back(d);
                if (!m_inpkt[s]) begin
                    if (d[31:30] == 2'b01) begin m_inpkt[s] = 1; m_dest[s] = d[7:0]; end
                    else m_err[s] = 1'b1;
                end else begin
                    if (d[31:30] == 2'b11) m_inpkt[s] = 0;
                    else if (d[31:30] == 2'b01) begin m_err[s] = 1'b1; m_dest[s] = d[7:0]; end
                    else if (d[31:30] == 2'b00) m_err[s] = 1'b1;
                end
            end
            m_slot = (m_slot + 1) % VC;
        end
        @(negedge clk);
    endtask

    task automatic go_to_slot(input int s, input logic [VC-1:0] rd);
        while (m_slot != s) tick(1'b0, 1'b0, '0, rd);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 32'h4000_0000, '1);
        tick(1'b1, 1'b1, 32'h4000_0000, '1);
        checks++; if (slot !== 2'd0) begin errors++; $display("FAIL reset_slot got=%0d want=0", slot); end
        checks++; if (vc_valid_out !== '0) begin errors++; $display("FAIL reset_valid got=%b want=0", vc_valid_out); end
        checks++; if (vc_data_out !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", vc_data_out); end
        checks++; if (vc_dest !== '0 || vc_err !== '0) begin errors++; $display("FAIL reset_dest_err got=%h/%b want=0/0", vc_dest, vc_err); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_in); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] f;
        for (int i = 0; i < 4 * VC; i++) begin
            f = pkt_flit(i % VC, i / VC);
            checks++; if (ready_in !== 1'b1 || slot !== 2'(i % VC)) begin
                errors++; $display("FAIL stream_ready cyc=%0d got ready=%b slot=%0d want ready=1 slot=%0d", i, ready_in, slot, i % VC); end
            tick(1'b0, 1'b1, f, '1);
            checks++; if (vc_valid_out[i % VC] !== 1'b1 || vc_data_out[(i % VC)*DW +: DW] !== f) begin
                errors++; $display("FAIL stream_data cyc=%0d got v=%b d=%h want v=1 d=%h", i, vc_valid_out[i % VC], vc_data_out[(i % VC)*DW +: DW], f); end
        end
        checks++; if (vc_dest[15:8] !== 8'h03 || vc_err !== '0) begin
            errors++; $display("FAIL stream_dest_err got dest1=%h err=%b want 03/0", vc_dest[15:8], vc_err); end
    endtask

    task automatic test_backpressure();
        int idx [VC];
        int n2;
        bit exp_r;
        int s;
        n2 = 0;
        for (int k = 0; k < VC; k++) idx[k] = 0;
        go_to_slot(0, 4'b1011);
        for (int i = 0; i < 6 * VC; i++) begin
            s = m_slot;
            exp_r = (s != 2) || (n2 < FD);
            checks++; if (ready_in !== exp_r) begin
                errors++; $display("FAIL bp_ready cyc=%0d slot=%0d got=%b want=%b", i, s, ready_in, exp_r); end
            tick(1'b0, 1'b1, pkt_flit(s, idx[s]), 4'b1011);
            if (exp_r) begin idx[s]++; if (s == 2) n2++; end
            checks++; if (vc_valid_out !== exp_valid() || vc_data_out !== exp_data() || vc_err !== m_err) begin
                errors++; $display("FAIL bp_model cyc=%0d got v=%b d=%h e=%b want v=%b d=%h e=%b", i, vc_valid_out, vc_data_out, vc_err, exp_valid(), exp_data(), m_err); end
        end
        go_to_slot(2, 4'b1011);
        checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ready got=%b want=0", ready_in); end
        tick(1'b0, 1'b1, pkt_flit(2, idx[2]), 4'b1111);
        checks++; if (vc_valid_out[2] !== 1'b1 || vc_data_out[2*DW +: DW] !== pkt_flit(2, 1)) begin
            errors++; $display("FAIL bp_after_pop got v=%b d=%h want v=1 d=%h", vc_valid_out[2], vc_data_out[2*DW +: DW], pkt_flit(2, 1)); end
        go_to_slot(2, 4'b1011);
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL bp_retry_ready got=%b want=1", ready_in); end
        tick(1'b0, 1'b1, pkt_flit(2, idx[2]), 4'b1011);
        checks++; if (vc_valid_out !== exp_valid() || vc_data_out !== exp_data() || mq[2].size() != FD) begin
            errors++; $display("FAIL bp_retry got v=%b d=%h want v=%b d=%h", vc_valid_out, vc_data_out, exp_valid(), exp_data()); end
        for (int i = 0; i < 2 * FD * VC; i++) tick(1'b0, 1'b0, '0, '1);
        checks++; if (vc_valid_out !== '0) begin errors++; $display("FAIL bp_drain got=%b want=0", vc_valid_out); end
    endtask

    task automatic test_empty_write();
        go_to_slot(0, '1);
        checks++; if (vc_valid_out[0] !== 1'b0) begin errors++; $display("FAIL ew_pre got=%b want=0", vc_valid_out[0]); end
        tick(1'b0, 1'b1, 32'hC0AB_CDEF, '1);
        checks++; if (vc_valid_out[0] !== 1'b1 || vc_data_out[DW-1:0] !== 32'hC0AB_CDEF) begin
            errors++; $display("FAIL ew_visible got v=%b d=%h want v=1 d=c0abcdef", vc_valid_out[0], vc_data_out[DW-1:0]); end
        tick(1'b0, 1'b0, '0, '1);
        checks++; if (vc_valid_out[0] !== 1'b0) begin errors++; $display("FAIL ew_popped got=%b want=0", vc_valid_out[0]); end
        tick(1'b0, 1'b0, '0, '1);
        checks++; if (vc_valid_out !== exp_valid() || vc_data_out !== exp_data()) begin
            errors++; $display("FAIL ew_no_underflow got v=%b d=%h want v=%b d=%h", vc_valid_out, vc_data_out, exp_valid(), exp_data()); end
    endtask

    task automatic test_err();
        tick(1'b1, 1'b0, '0, '1);
        go_to_slot(3, '1);
        checks++; if (vc_err[3] !== 1'b0) begin errors++; $display("FAIL err_pre got=%b want=0", vc_err[3]); end
        tick(1'b0, 1'b1, 32'h8000_0000, '1);
        checks++; if (vc_err[3] !== 1'b1 || vc_valid_out[3] !== 1'b1 || vc_data_out[3*DW +: DW] !== 32'h8000_0000) begin
            errors++; $display("FAIL err_flag got e=%b v=%b d=%h want e=1 v=1 d=80000000", vc_err[3], vc_valid_out[3], vc_data_out[3*DW +: DW]); end
        for (int k = 0; k < 4; k++) begin
            go_to_slot(3, '1);
            tick(1'b0, 1'b1, pkt_flit(3, k), '1);
        end
        checks++; if (vc_err !== 4'b1000 || vc_dest[31:24] !== 8'h05) begin
            errors++; $display("FAIL err_sticky got e=%b dest3=%h want e=1000 dest3=05", vc_err, vc_dest[31:24]); end
        tick(1'b1, 1'b0, '0, '1);
        checks++; if (vc_err !== '0) begin errors++; $display("FAIL err_clear got=%b want=0", vc_err); end
    endtask

    task automatic test_reset_mid_packet();
        tick(1'b1, 1'b0, '0, '1);
        tick(1'b0, 1'b1, pkt_flit(0, 0), 4'b1110);
        go_to_slot(0, 4'b1110);
        tick(1'b0, 1'b1, pkt_flit(0, 1), 4'b1110);
        checks++; if (vc_valid_out[0] !== 1'b1) begin errors++; $display("FAIL mid_loaded got=%b want=1", vc_valid_out[0]); end
        tick(1'b1, 1'b1, pkt_flit(0, 2), '1);
        checks++; if (slot !== 2'd0 || vc_valid_out !== '0 || vc_err !== '0 || vc_dest !== '0) begin
            errors++; $display("FAIL mid_reset got slot=%0d v=%b e=%b dest=%h want 0/0/0/0", slot, vc_valid_out, vc_err, vc_dest); end
        tick(1'b0, 1'b1, 32'h4000_0077, 4'b1110);
        checks++; if (vc_err !== '0 || vc_dest[7:0] !== 8'h77 || vc_valid_out[0] !== 1'b1) begin
            errors++; $display("FAIL mid_new_head got e=%b dest0=%h v0=%b want 0/77/1", vc_err, vc_dest[7:0], vc_valid_out[0]); end
    endtask

    task automatic test_random();
        logic [DW-1:0]  d;
        logic           v;
        logic [VC-1:0]  rd;
        for (int i = 0; i < 400; i++) begin
            d  = $urandom;
            v  = ($urandom_range(0, 3) != 0);
            rd = VC'($urandom);
            checks++; if (ready_in !== (mq[m_slot].size() < FD) || slot !== 2'(m_slot)) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got ready=%b slot=%0d want ready=%b slot=%0d", i, ready_in, slot, mq[m_slot].size() < FD, m_slot); end
            tick(1'b0, v, d, rd);
            checks++; if (vc_valid_out !== exp_valid() || vc_data_out !== exp_data() || vc_dest !== exp_dest() || vc_err !== m_err) begin
                errors++; $display("FAIL rnd_out cyc=%0d got v=%b d=%h dest=%h e=%b want v=%b d=%h dest=%h e=%b", i, vc_valid_out, vc_data_out, vc_dest, vc_err, exp_valid(), exp_data(), exp_dest(), m_err); end
        end
    endtask

`ifdef VC_RX_STATS_EN
    task automatic test_stats();
        logic [VC*16-1:0] tmp;
        tick(1'b1, 1'b0, '0, '1);
        for (int k = 0; k < 12; k++) begin
            go_to_slot(1, '1);
            tick(1'b0, 1'b1, pkt_flit(1, k), '1);
        end
        checks++; if (vc_pkt_cnt[31:16] !== 16'd3 || vc_flit_cnt[31:16] !== 16'd12) begin
            errors++; $display("FAIL stats_count got pkt=%0d flit=%0d want 3/12", vc_pkt_cnt[31:16], vc_flit_cnt[31:16]); end
        tmp = vc_pkt_cnt;
        tmp[31:16] = 16'hFFFF;
        force dut.pkt_cnt_reg = tmp;
        #1;
        release dut.pkt_cnt_reg;
        for (int k = 0; k < 4; k++) begin
            go_to_slot(1, '1);
            tick(1'b0, 1'b1, pkt_flit(1, k), '1);
        end
        checks++; if (vc_pkt_cnt[31:16] !== 16'd0 || vc_flit_cnt[31:16] !== 16'd16) begin
            errors++; $display("FAIL stats_wrap got pkt=%0d flit=%0d want 0/16", vc_pkt_cnt[31:16], vc_flit_cnt[31:16]); end
    endtask
`endif

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; vc_ready_out = '0;
        m_slot = 0; m_err = '0;
        for (int k = 0; k < VC; k++) begin m_inpkt[k] = 0; m_dest[k] = 8'h00; end
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_write();
        test_err();
        test_reset_mid_packet();
        test_random();
`ifdef VC_RX_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_rx_demux.md
Name: vc_rx_demux

Overview:
- Router-side receiver for the time-multiplexed virtual-channel local injection port, used at the node-to-router boundary.
- The node-side injector presents VC slot s on data_in/valid_in during cycles where its slot counter equals s. This block runs the matching slot counter, steers accepted flits into per-VC FIFOs and checks per-VC packet framing.
- It exposes each VC as an independent valid/ready stream to the router input unit.

Parameters:
- VC, 4, number of virtual channels and slot-rotation length (2..8).
- DATA_WIDTH, 32, flit width.
- FIFO_DEPTH, 4, entries per VC FIFO (power of two, >=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- data_in  input  DATA_WIDTH  flit from node for the current slot.
- valid_in  input  1  flit valid for the current slot.
- ready_in  output  1  the current slot's VC FIFO can accept.
- slot  output  $clog2(VC)  current slot index (debug/lockstep check).
- vc_data_out  output  VC*DATA_WIDTH  head-of-FIFO flit per VC; VC v occupies bits [v*DATA_WIDTH +: DATA_WIDTH].
- vc_valid_out  output  VC  per-VC FIFO non-empty.
- vc_ready_out  input  VC  per-VC consumer ready.
- vc_dest  output  VC*8  destination field (bits [7:0]) latched from the last head flit per VC.
- vc_err  output  VC  sticky per-VC framing error.

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Flit type is data_in[31:30]:
  - 01 = head
  - 10 = body
  - 11 = tail
  - 00 = illegal
- Head fields: message id [29:16], source [15:8], destination [7:0].
- Slot counter:
  - Reset to 0.
  - Increments every cycle; wraps from VC-1 to 0.
  - Never stalls; it runs in lockstep with the node-side counter released from reset on the same edge.
- ready_in = !full[slot]. It is combinational from the slot and FIFO counts; it never depends on valid_in.
- Accept when valid_in & ready_in at the posedge. The flit is written to FIFO[slot]. Only one VC can be written per cycle.
- FIFOs:
  - First-word fall-through. vc_data_out[v] shows the oldest entry whenever vc_valid_out[v]=1.
  - Pop on vc_valid_out[v] & vc_ready_out[v].
  - Accept-to-visible latency is 1 cycle: a flit written at edge N gives vc_valid_out=1 after edge N.
- Full FIFO with simultaneous pop:
  - ready_in is computed from the pre-pop count, so the write is refused that cycle. There is no bypass.
  - The node retries on a later rotation of the same slot.
- Empty FIFO with simultaneous write: the write lands, and no pop occurs that cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits, ranging 0..FIFO_DEPTH.
- Per-VC framing FSM, advanced only on accepted flits of that VC:
  - IDLE: head -> IN_PKT and latch vc_dest. Body, tail or 00 -> set vc_err, stay IDLE.
  - IN_PKT: body -> IN_PKT. Tail -> IDLE. Head -> set vc_err, relatch vc_dest, stay IN_PKT. 00 -> set vc_err, stay IN_PKT.
  - Erroneous flits are still stored; the FSM only flags.
- vc_err is cleared only by reset.
- Reset values:
  - slot=0; all FIFOs empty (vc_valid_out=0).
  - vc_data_out=0; vc_dest=0; vc_err=0; FSMs in IDLE.
  - ready_in=1 (slot 0 empty).
- Reset mid-packet:
  - All FIFO contents are discarded; FSMs return to IDLE.
  - Reset has priority over any write or pop in the same cycle.

Optional Feature:
- Macro: VC_RX_STATS_EN.
- When defined, add output vc_pkt_cnt (VC*16) and output vc_flit_cnt (VC*16):
  - Per-VC counts of accepted tails and of accepted flits.
  - Reset to 0; wrap 0xFFFF -> 0.
  - Updated on the accept edge.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
- Reset, then valid_in=1 every cycle carrying a 4-flit packet on each slot with all vc_ready_out=1 → ready_in=1 throughout. Each VC receives head/body/body/tail in order: 0x4001_1203, 0x8001_0000, 0x8001_0001, 0xC001_0002 (shown for VC1). vc_dest[1]=0x03, vc_err=0.
- Hold vc_ready_out[2]=0 and offer slot 2 every rotation → exactly 4 flits are accepted, after which ready_in=0 in slot-2 cycles only; other slots keep accepting. Raise vc_ready_out[2] for one cycle in the slot-2 cycle → that write is refused, and the next slot-2 cycle accepts.
- Empty VC0; write in a slot-0 cycle while vc_ready_out[0]=1 → vc_valid_out[0] rises after that edge, the first pop follows next cycle, and the count never underflows.
- On VC3 send a body flit 0x8000_0000 while IDLE → vc_err[3]=1 and the flit is still delivered. A subsequent normal packet completes; vc_err[3] stays 1 until rst.
- Assert rst after 2 of 4 flits of a packet on VC0 → after reset slot=0, vc_valid_out=0, and the FSM is IDLE. A new head is accepted with no error.
- With VC_RX_STATS_EN defined, send 3 packets of 4 flits on VC1 → vc_pkt_cnt[1]=3 and vc_flit_cnt[1]=12. Preload the counter to 0xFFFF via a 65535-packet force → the next tail wraps it to 0.
